// File: rtl/router_pkg.sv
// Shared packet layout and injection-stage state encoding for the router node interface.
package router_pkg;

  localparam int PKT_W     = 29;
  localparam int ADDR_W    = 4;
  localparam int PAYLOAD_W = 24;
  localparam int DEST_MSB  = 28;
  localparam int DEST_LSB  = 25;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    GAP
  } inject_state_t;

  function automatic logic [ADDR_W-1:0] pkt_dest(input logic [PKT_W-1:0] pkt);
    return pkt[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read; DEPTH must be a power of two so pointers wrap for free.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/node_inject_queue.sv
// Node-side injection queue: buffers node packets, offers the head to the router core and keeps debug stats.
//   state | meaning
//   IDLE  | nothing offered; waits for a stored packet
//   OFFER | head packet held on Packet_From_Node with Valid high until Core_Load_Ack
//   GAP   | one forced Valid-low cycle after each accepted packet
module node_inject_queue
  import router_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                   Clk_R,
  input  logic                   Rst,
  input  logic [ADDR_W-1:0]      r_addr,
  input  logic                   wr_valid,
  input  logic [PKT_W-1:0]       wr_data,
  output logic                   wr_ready,
  output logic [PKT_W-1:0]       Packet_From_Node,
  output logic                   Packet_From_Node_Valid,
  input  logic                   Core_Load_Ack,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   ack_timeout,
  output logic [CNT_W-1:0]       sent_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  inject_state_t    state;
  inject_state_t    state_nx;
  logic             full;
  logic             empty;
  logic [PKT_W-1:0] head;
  logic             accept;
  logic             self_addr;
  logic             push;
  logic             pop;
  logic             no_ack;
  logic [TW-1:0]    tmr;

  assign wr_ready  = !full && !Rst;
  assign accept    = wr_valid && wr_ready;
  assign self_addr = (pkt_dest(wr_data) == r_addr);
  assign push      = accept && !self_addr;
  assign pop       = (state == OFFER) && Core_Load_Ack;
  assign no_ack    = (state == OFFER) && !Core_Load_Ack;

  assign Packet_From_Node_Valid = (state == OFFER);

  sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk_R),
    .rst   (Rst),
    .push  (push),
    .pop   (pop),
    .din   (wr_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count),
    .head  (head)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = OFFER;
      OFFER:   if (Core_Load_Ack) state_nx = GAP;
      GAP:     state_nx = empty ? IDLE : OFFER;
      default: state_nx = IDLE;
    endcase
  end

  // Timer counts down from TIMEOUT over unacked offer cycles; terminal count raises the sticky flag.
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      state            <= IDLE;
      Packet_From_Node <= '0;
      tmr              <= '0;
      overflow         <= 1'b0;
      ack_timeout      <= 1'b0;
      sent_cnt         <= '0;
      drop_cnt         <= '0;
    end else begin
      state <= state_nx;
      if ((state != OFFER) && (state_nx == OFFER)) begin
        Packet_From_Node <= head;
        tmr              <= TW'(TIMEOUT);
      end else if (no_ack && (tmr != '0)) begin
        tmr <= tmr - TW'(1);
      end
      if (no_ack && (tmr <= TW'(1))) ack_timeout <= 1'b1;
      if (wr_valid && !wr_ready) overflow <= 1'b1;
      if (pop && (sent_cnt != '1)) sent_cnt <= sent_cnt + CNT_W'(1);
      if (accept && self_addr && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_node_inject_queue.sv
// Randomized bench: a queue-based reference model predicts state each cycle; a scoreboard checks offered packets in order.
module tb_node_inject_queue;
  import router_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 10;
  localparam int CNT_W   = 4;
  localparam int SAT     = (1 << CNT_W) - 1;
  localparam int NPH     = 10;

  logic             Clk_R = 1'b0;
  logic             Rst = 1'b1;
  logic [3:0]       r_addr = 4'h0;
  logic             wr_valid = 1'b0;
  logic [28:0]      wr_data = '0;
  logic             Core_Load_Ack = 1'b0;
  logic             wr_ready;
  logic [28:0]      Packet_From_Node;
  logic             Packet_From_Node_Valid;
  logic [2:0]       fifo_count;
  logic             overflow;
  logic             ack_timeout;
  logic [CNT_W-1:0] sent_cnt;
  logic [CNT_W-1:0] drop_cnt;

  node_inject_queue #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .Clk_R                  (Clk_R),
    .Rst                    (Rst),
    .r_addr                 (r_addr),
    .wr_valid               (wr_valid),
    .wr_data                (wr_data),
    .wr_ready               (wr_ready),
    .Packet_From_Node       (Packet_From_Node),
    .Packet_From_Node_Valid (Packet_From_Node_Valid),
    .Core_Load_Ack          (Core_Load_Ack),
    .fifo_count             (fifo_count),
    .overflow               (overflow),
    .ack_timeout            (ack_timeout),
    .sent_cnt               (sent_cnt),
    .drop_cnt               (drop_cnt)
  );

  always #5 Clk_R = ~Clk_R;

  int compared   = 0;
  int mismatched = 0;

  logic [28:0] exp_q[$];
  logic [28:0] mq[$];
  bit m_valid, m_over, m_to, started;
  int m_tmr, m_sent, m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advances the reference model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit ready, nv;
    if (Rst) begin
      mq.delete();
      exp_q.delete();
      m_valid = 0; m_over = 0; m_to = 0;
      m_tmr = 0; m_sent = 0; m_drop = 0;
      return;
    end
    ready = (mq.size() != DEPTH);
    nv = m_valid ? !Core_Load_Ack : (mq.size() > 0);
    if (m_valid && !Core_Load_Ack) begin
      if (m_tmr < TIMEOUT) m_tmr++;
      if (m_tmr == TIMEOUT) m_to = 1;
    end
    if (nv && !m_valid) m_tmr = 0;
    if (m_valid && Core_Load_Ack) begin
      void'(mq.pop_front());
      if (m_sent < SAT) m_sent++;
    end
    if (wr_valid) begin
      if (!ready) m_over = 1;
      else if (wr_data[28:25] == r_addr) begin
        if (m_drop < SAT) m_drop++;
      end else begin
        mq.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
    end
    m_valid = nv;
  endtask

  always @(negedge Clk_R) begin
    if (started) begin
      check("valid", 32'(Packet_From_Node_Valid), 32'(m_valid));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("wr_ready", 32'(wr_ready), 32'(!Rst && (mq.size() != DEPTH)));
      check("overflow", 32'(overflow), 32'(m_over));
      check("ack_timeout", 32'(ack_timeout), 32'(m_to));
      check("sent_cnt", 32'(sent_cnt), 32'(m_sent));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (Packet_From_Node_Valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("offer_without_expected", 32'(1), 32'(0));
        end else begin
          check("packet", 32'(Packet_From_Node), 32'(exp_q[0]));
          if (Core_Load_Ack && !Rst) void'(exp_q.pop_front());
        end
      end
    end
  end

  int ack_pct [NPH] = '{0, 5, 50, 100, 20, 0, 70, 10, 100, 40};
  int wr_pct  [NPH] = '{90, 60, 40, 80, 30, 50, 90, 70, 20, 60};

  initial begin
    @(posedge Clk_R); #1;
    model_step();
    started = 1;
    for (int ph = 0; ph < NPH; ph++) begin
      Rst = 1'b1;
      r_addr = 4'($urandom_range(0, 15));
      wr_valid = 1'($urandom_range(0, 1));
      Core_Load_Ack = 1'($urandom_range(0, 1));
      @(posedge Clk_R); #1;
      model_step();
      Rst = 1'b0;
      for (int n = 0; n < 300; n++) begin
        wr_valid = ($urandom_range(0, 99) < wr_pct[ph]);
        wr_data = 29'($urandom());
        if ($urandom_range(0, 3) == 0) wr_data[28:25] = r_addr;
        Core_Load_Ack = ($urandom_range(0, 99) < ack_pct[ph]);
        @(posedge Clk_R); #1;
        model_step();
      end
    end
    wr_valid = 1'b0;
    Core_Load_Ack = 1'b0;
    repeat (4) begin
      @(posedge Clk_R); #1;
      model_step();
    end
    @(negedge Clk_R); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
